// File: rtl/ascon_pack.sv
// Shared round counts, mode encoding and sequencer state type for the ASCON round logic.
package ascon_pack;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;
  localparam int ROUNDS_C = 6;

  typedef enum logic [1:0] {
    MODE_A   = 2'b00,
    MODE_B   = 2'b01,
    MODE_C   = 2'b10,
    MODE_RSV = 2'b11
  } type_round_mode;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } type_seq_state;

endpackage

// File: rtl/round_count_lut.sv
// Mode to start-index decode: a run of N rounds starts at ROUNDS_MAX-N so it always ends on ROUNDS_MAX-1.
// Purely combinational, no handshake.
module round_count_lut
  import ascon_pack::*;
#(
  parameter int ROUNDS_MAX = ascon_pack::ROUNDS_A,
  parameter int ROUNDS_B   = ascon_pack::ROUNDS_B,
  parameter int ROUNDS_C   = ascon_pack::ROUNDS_C,
  parameter int CNT_W      = 4
) (
  input  logic [1:0]       mode_i,
  output logic [CNT_W-1:0] start_idx_o
);

  always_comb begin
    start_idx_o = '0;
    case (type_round_mode'(mode_i))
      MODE_B:   start_idx_o = CNT_W'(ROUNDS_MAX - ROUNDS_B);
      MODE_C:   start_idx_o = CNT_W'(ROUNDS_MAX - ROUNDS_C);
      MODE_A:   start_idx_o = '0;
      MODE_RSV: start_idx_o = '0;
      default:  start_idx_o = '0;
    endcase
  end

endmodule

// File: rtl/ascon_round_sequencer.sv
// Round index sequencer for the ASCON permutation: start/done handshake, mode-selected round count.
// N RUN cycles per run with done one cycle later; ena_i=0 stalls one cycle each, abort_i cancels without done.
module ascon_round_sequencer
  import ascon_pack::*;
#(
  parameter int ROUNDS_MAX = ascon_pack::ROUNDS_A,
  parameter int ROUNDS_B   = ascon_pack::ROUNDS_B,
  parameter int ROUNDS_C   = ascon_pack::ROUNDS_C,
  parameter int CNT_W      = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             ena_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] round_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o
);

  if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_MAX) begin : g_bad_rounds_b
    $error("ROUNDS_B must be in 1..ROUNDS_MAX");
  end
  if (ROUNDS_C < 1 || ROUNDS_C > ROUNDS_MAX) begin : g_bad_rounds_c
    $error("ROUNDS_C must be in 1..ROUNDS_MAX");
  end
  if (CNT_W < $clog2(ROUNDS_MAX)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for ROUNDS_MAX");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS_MAX - 1);

  type_seq_state    state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] start_idx_q, start_idx_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] lut_idx;

  round_count_lut #(
    .ROUNDS_MAX (ROUNDS_MAX),
    .ROUNDS_B   (ROUNDS_B),
    .ROUNDS_C   (ROUNDS_C),
    .CNT_W      (CNT_W)
  ) u_lut (
    .mode_i      (mode_i),
    .start_idx_o (lut_idx)
  );

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    start_idx_d = start_idx_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous abort here; abort only matters in RUN
        round_d = '0;
        if (start_i) begin
          state_d     = ST_RUN;
          round_d     = lut_idx;
          start_idx_d = lut_idx;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          round_d = '0;
        end else if (ena_i) begin
          if (round_q == LAST_IDX) begin
            state_d = ST_IDLE;
            round_d = '0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      start_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      start_idx_q <= start_idx_d;
      done_q      <= done_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = (state_q == ST_RUN);
  assign round_o = round_q;
  assign first_o = busy_o && (round_q == start_idx_q);
  assign last_o  = busy_o && (round_q == LAST_IDX);
  assign done_o  = done_q;

endmodule
